present_sbox_nibble_scheduler: RTL and testbench

//  Sequences the 64-bit two-share PRESENT state through the single shared masked
//  4-bit S-box stage (GHPC gadget, 2 shares). Issues one nibble per cycle and forwards

---
 rtl/present_sbox_nibble_scheduler_pkg.sv | 21 ++
 rtl/present_sbox_nibble_scheduler_if.sv | 31 +++
 rtl/present_sbox_nibble_scheduler_valid_pipe.sv | 41 ++++
 rtl/present_sbox_nibble_scheduler.sv | 96 +++++++++
 tb/tb_present_sbox_nibble_scheduler.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/present_sbox_nibble_scheduler_pkg.sv
// Shared constants and FSM encoding for the PRESENT masked S-layer nibble scheduler.
package present_sbox_nibble_scheduler_pkg;

  localparam int NUM_NIBBLES = 16;
  localparam int NIBBLE_W    = 4;
  localparam int STATE_W     = NUM_NIBBLES * NIBBLE_W;
  localparam int IDX_W       = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } sched_state_t;

  // Bit offset of nibble idx inside a 64-bit share.
  function automatic logic [5:0] nib_lsb(input logic [IDX_W-1:0] idx);
    return {idx, 2'b00};
  endfunction

endpackage

// File: rtl/present_sbox_nibble_scheduler_if.sv
// Bus between the scheduler, the round datapath, the PRNG and the shared masked S-box.
interface present_sbox_nibble_scheduler_if;
  import present_sbox_nibble_scheduler_pkg::*;

  logic               start;
  logic [STATE_W-1:0] state_in0;
  logic [STATE_W-1:0] state_in1;
  logic               busy;
  logic               done;
  logic [STATE_W-1:0] state_out0;
  logic [STATE_W-1:0] state_out1;
  logic [3:0]         sbox_in0;
  logic [3:0]         sbox_in1;
  logic [3:0]         sbox_r;
  logic               r_req;
  logic [3:0]         r_in;
  logic [3:0]         sbox_out0;
  logic [3:0]         sbox_out1;

  // master: the surrounding round datapath, PRNG and S-box gadget
  modport master (
    output start, state_in0, state_in1, r_in, sbox_out0, sbox_out1,
    input  busy, done, state_out0, state_out1, sbox_in0, sbox_in1, sbox_r, r_req
  );

  modport slave (
    input  start, state_in0, state_in1, r_in, sbox_out0, sbox_out1,
    output busy, done, state_out0, state_out1, sbox_in0, sbox_in1, sbox_r, r_req
  );

endinterface

// File: rtl/present_sbox_nibble_scheduler_valid_pipe.sv
// LATENCY-deep valid + nibble-index delay line matching the S-box gadget pipeline.
module present_sbox_valid_pipe
  import present_sbox_nibble_scheduler_pkg::*;
#(
  parameter int LATENCY = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [IDX_W-1:0] in_idx,
  output logic             out_valid,
  output logic [IDX_W-1:0] out_idx
);

  if (LATENCY == 0) begin : g_comb
    assign out_valid = in_valid;
    assign out_idx   = in_idx;
  end else begin : g_pipe
    logic [LATENCY-1:0] vld_q;
    logic [IDX_W-1:0]   idx_q [LATENCY];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        vld_q <= '0;
        for (int k = 0; k < LATENCY; k++) idx_q[k] <= '0;
      end else begin
        // NOTE: non-blocking assignments make every stage shift from its pre-edge neighbour.
        vld_q[0] <= in_valid;
        idx_q[0] <= in_idx;
        for (int k = 1; k < LATENCY; k++) begin
          vld_q[k] <= vld_q[k-1];
          idx_q[k] <= idx_q[k-1];
        end
      end
    end

    assign out_valid = vld_q[LATENCY-1];
    assign out_idx   = idx_q[LATENCY-1];
  end

endmodule

// File: rtl/present_sbox_nibble_scheduler.sv
// Streams both PRESENT state shares nibble-serially through one shared masked S-box
// and writes the pipelined results back, keeping share paths strictly separate.
module present_sbox_nibble_scheduler
  import present_sbox_nibble_scheduler_pkg::*;
#(
  parameter int LATENCY = 1,
  parameter int NIBBLES = NUM_NIBBLES
) (
  input logic                            clk,
  input logic                            rst,
  present_sbox_nibble_scheduler_if.slave bus
);

  localparam logic [IDX_W-1:0] ISSUE_LAST = IDX_W'(NIBBLES - 1);
  localparam logic [2:0]       DRAIN_LAST = 3'((LATENCY == 0) ? 0 : LATENCY - 1);

  sched_state_t       state, state_nxt;
  logic [IDX_W-1:0]   issue_idx;
  logic [IDX_W-1:0]   cap_idx;
  logic [2:0]         drain_cnt;
  logic [STATE_W-1:0] src0, src1;
  logic [STATE_W-1:0] res0, res1;
  logic               issue_en;
  logic               start_ok;
  logic               cap_en;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    // NOTE: defaulting state_nxt first keeps every path assigned, so no latch is inferred.
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = ISSUE;
      ISSUE:   if (issue_idx == ISSUE_LAST) state_nxt = (LATENCY == 0) ? DONE : DRAIN;
      DRAIN:   if (drain_cnt == DRAIN_LAST) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    issue_en = (state == ISSUE);
    start_ok = (state == IDLE) && bus.start;
  end

  assign bus.busy     = (state == ISSUE) || (state == DRAIN);
  assign bus.done     = (state == DONE);
  assign bus.r_req    = issue_en;
  assign bus.sbox_r   = issue_en ? bus.r_in : 4'h0;
  // Outside ISSUE the gadget sees zeros, never stale share data.
  assign bus.sbox_in0 = issue_en ? src0[nib_lsb(issue_idx) +: NIBBLE_W] : 4'h0;
  assign bus.sbox_in1 = issue_en ? src1[nib_lsb(issue_idx) +: NIBBLE_W] : 4'h0;

  // Write-back is timed by the valid pipe, so issue and drain may overlap freely.
  present_sbox_valid_pipe #(.LATENCY(LATENCY)) u_valid_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (issue_en),
    .in_idx    (issue_idx),
    .out_valid (cap_en),
    .out_idx   (cap_idx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      src0      <= '0;
      src1      <= '0;
      res0      <= '0;
      res1      <= '0;
      issue_idx <= '0;
      drain_cnt <= '0;
    end else begin
      if (start_ok) begin
        src0 <= bus.state_in0;
        src1 <= bus.state_in1;
      end
      // 4-bit index naturally wraps 15 -> 0 on the last issue cycle.
      if (issue_en) issue_idx <= issue_idx + 1'b1;
      drain_cnt <= (state == DRAIN) ? drain_cnt + 1'b1 : 3'd0;
      if (cap_en) begin
        res0[nib_lsb(cap_idx) +: NIBBLE_W] <= bus.sbox_out0;
        res1[nib_lsb(cap_idx) +: NIBBLE_W] <= bus.sbox_out1;
      end
    end
  end

  assign bus.state_out0 = res0;
  assign bus.state_out1 = res1;

endmodule

// File: tb/tb_present_sbox_nibble_scheduler.sv
// Directed bench: three scheduler builds (LATENCY 1/0/3), each driving a 2-share S-box model.
module tb_present_sbox_nibble_scheduler;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total  = 0;
  int   passed = 0;

  localparam logic [63:0] VEC_A = 64'h0123456789ABCDEF;
  localparam logic [63:0] EXP_A = 64'hC56B90AD3EF84712;
  localparam logic [63:0] VEC_B = 64'hFEDCBA9876543210;
  localparam logic [63:0] EXP_B = 64'h21748FE3DA09B65C;
  localparam logic [63:0] EXP_Z = 64'hCCCCCCCCCCCCCCCC;

  always #5 clk = ~clk;

  present_sbox_nibble_scheduler_if b1 ();
  present_sbox_nibble_scheduler_if b0 ();
  present_sbox_nibble_scheduler_if b3 ();

  present_sbox_nibble_scheduler #(.LATENCY(1)) u1 (.clk(clk), .rst(rst), .bus(b1.slave));
  present_sbox_nibble_scheduler #(.LATENCY(0)) u0 (.clk(clk), .rst(rst), .bus(b0.slave));
  present_sbox_nibble_scheduler #(.LATENCY(3)) u3 (.clk(clk), .rst(rst), .bus(b3.slave));

  // Unmasked PRESENT S-box; entry x lives at nibble x of the table.
  function automatic logic [3:0] sbox(input logic [3:0] x);
    logic [63:0] tbl;
    tbl = 64'h21748FE3DA09B65C;
    return tbl[{x, 2'b00} +: 4];
  endfunction

  // Masked gadget model: out0 ^ out1 == S(in0 ^ in1), remasked by r.
  logic [3:0] m1_0, m1_1;
  logic [3:0] p3_0 [3];
  logic [3:0] p3_1 [3];

  always @(posedge clk) begin
    m1_0    <= sbox(b1.sbox_in0 ^ b1.sbox_in1) ^ b1.sbox_r ^ b1.sbox_in1;
    m1_1    <= b1.sbox_r ^ b1.sbox_in1;
    p3_0[0] <= sbox(b3.sbox_in0 ^ b3.sbox_in1) ^ b3.sbox_r ^ b3.sbox_in1;
    p3_1[0] <= b3.sbox_r ^ b3.sbox_in1;
    p3_0[1] <= p3_0[0];
    p3_1[1] <= p3_1[0];
    p3_0[2] <= p3_0[1];
    p3_1[2] <= p3_1[1];
  end

  assign b1.sbox_out0 = m1_0;
  assign b1.sbox_out1 = m1_1;
  assign b0.sbox_out0 = sbox(b0.sbox_in0 ^ b0.sbox_in1) ^ b0.sbox_r ^ b0.sbox_in1;
  assign b0.sbox_out1 = b0.sbox_r ^ b0.sbox_in1;
  assign b3.sbox_out0 = p3_0[2];
  assign b3.sbox_out1 = p3_1[2];

  always @(negedge clk) begin
    b1.r_in = 4'($urandom);
    b0.r_in = 4'($urandom);
    b3.r_in = 4'($urandom);
  end

  // One run on the LATENCY=1 build; start lands in the cycle after the caller's last negedge.
  task automatic run1(input logic [63:0] in0, input logic [63:0] in1, input logic [63:0] exp_res,
                      input bit per_cycle, input string name);
    int          k;
    int          rreq;
    bit          seen;
    logic [63:0] x;
    @(negedge clk);
    b1.state_in0 = in0;
    b1.state_in1 = in1;
    b1.start     = 1'b1;
    @(negedge clk);
    b1.start = 1'b0;
    k    = 1;
    rreq = 0;
    seen = 1'b0;
    while (!seen && k < 60) begin
      if (b1.r_req) rreq++;
      if (per_cycle && k <= 16) begin
        total++;
        if ({b1.sbox_in1, b1.sbox_in0} !== {in1[4*(k-1) +: 4], in0[4*(k-1) +: 4]})
          $display("FAIL %s sbox_in idx %0d: got %h/%h expected %h/%h", name, k-1,
                   b1.sbox_in0, b1.sbox_in1, in0[4*(k-1) +: 4], in1[4*(k-1) +: 4]);
        else passed++;
      end
      if (per_cycle && k >= 3 && k <= 18) begin
        x = b1.state_out0 ^ b1.state_out1;
        total++;
        if (x[4*(k-3) +: 4] !== exp_res[4*(k-3) +: 4])
          $display("FAIL %s capture nibble %0d: got %h expected %h", name, k-3,
                   x[4*(k-3) +: 4], exp_res[4*(k-3) +: 4]);
        else passed++;
      end
      if (b1.done) seen = 1'b1;
      else begin
        @(negedge clk);
        k++;
      end
    end
    total++;
    if (!seen || k != 18) $display("FAIL %s done_cycle: got %0d (seen=%0b) expected 18", name, k, seen);
    else passed++;
    x = b1.state_out0 ^ b1.state_out1;
    total++;
    if (x !== exp_res) $display("FAIL %s result: got %h expected %h", name, x, exp_res);
    else passed++;
    total++;
    if (rreq != 16) $display("FAIL %s r_req_cycles: got %0d expected 16", name, rreq);
    else passed++;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    total++;
    if ({b1.busy, b1.done, b1.r_req} !== 3'b000)
      $display("FAIL reset_flags: got busy/done/r_req=%b expected 000", {b1.busy, b1.done, b1.r_req});
    else passed++;
    total++;
    if ({b1.state_out0, b1.state_out1} !== 128'h0)
      $display("FAIL reset_state_out: got %h_%h expected 0", b1.state_out0, b1.state_out1);
    else passed++;
    total++;
    if ({b1.sbox_in0, b1.sbox_in1, b1.sbox_r} !== 12'h000)
      $display("FAIL reset_sbox_bus: got %h expected 000", {b1.sbox_in0, b1.sbox_in1, b1.sbox_r});
    else passed++;
    rst = 1'b0;
    @(negedge clk);
    total++;
    if ({b1.busy, b0.busy, b3.busy} !== 3'b000)
      $display("FAIL idle_after_reset: got busy=%b expected 000", {b1.busy, b0.busy, b3.busy});
    else passed++;
  endtask

  task automatic test_case1();
    run1(VEC_A, 64'h0, EXP_A, 1'b0, "case1");
  endtask

  task automatic test_random_shares();
    logic [63:0] s;
    for (int n = 0; n < 100; n++) begin
      s = {$urandom, $urandom};
      run1(VEC_A ^ s, s, EXP_A, 1'b0, "rand_share");
    end
  endtask

  task automatic test_latency();
    int          k;
    int          d0, d3, n0, n3;
    logic [63:0] r0, r3;
    d0 = -1; d3 = -1; n0 = 0; n3 = 0; r0 = '0; r3 = '0;
    @(negedge clk);
    b0.state_in0 = '0; b0.state_in1 = '0; b0.start = 1'b1;
    b3.state_in0 = '0; b3.state_in1 = '0; b3.start = 1'b1;
    @(negedge clk);
    b0.start = 1'b0;
    b3.start = 1'b0;
    for (k = 1; k <= 30; k++) begin
      if (b0.done) begin
        n0++;
        if (d0 < 0) begin d0 = k; r0 = b0.state_out0 ^ b0.state_out1; end
      end
      if (b3.done) begin
        n3++;
        if (d3 < 0) begin d3 = k; r3 = b3.state_out0 ^ b3.state_out1; end
      end
      @(negedge clk);
    end
    total++;
    if (d0 != 17 || n0 != 1) $display("FAIL lat0_done: got cycle %0d count %0d expected 17/1", d0, n0);
    else passed++;
    total++;
    if (d3 != 20 || n3 != 1) $display("FAIL lat3_done: got cycle %0d count %0d expected 20/1", d3, n3);
    else passed++;
    total++;
    if (r0 !== EXP_Z) $display("FAIL lat0_result: got %h expected %h", r0, EXP_Z);
    else passed++;
    total++;
    if (r3 !== EXP_Z) $display("FAIL lat3_result: got %h expected %h", r3, EXP_Z);
    else passed++;
  endtask

  task automatic test_ignored_start();
    int          k;
    int          donek, ndone, busy_after;
    logic [63:0] res;
    donek = -1; ndone = 0; busy_after = 0; res = '0;
    @(negedge clk);
    b1.state_in0 = VEC_A; b1.state_in1 = '0; b1.start = 1'b1;
    @(negedge clk);
    for (k = 1; k <= 30; k++) begin
      if (b1.done) begin
        ndone++;
        if (donek < 0) begin donek = k; res = b1.state_out0 ^ b1.state_out1; end
      end
      if (donek >= 0 && k > donek && b1.busy) busy_after++;
      // Spurious start with poisoned data: once mid-ISSUE, once in the DONE cycle.
      b1.start     = (k == 5) || (k == donek);
      b1.state_in0 = b1.start ? 64'hFFFF_FFFF_FFFF_FFFF : VEC_A;
      @(negedge clk);
    end
    b1.start = 1'b0;
    total++;
    if (ndone != 1 || donek != 18) $display("FAIL ignore_start_done: got count %0d cycle %0d expected 1/18", ndone, donek);
    else passed++;
    total++;
    if (res !== EXP_A) $display("FAIL ignore_start_result: got %h expected %h", res, EXP_A);
    else passed++;
    total++;
    if (busy_after != 0) $display("FAIL ignore_start_busy: got %0d busy cycles after done expected 0", busy_after);
    else passed++;
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    b1.state_in0 = VEC_A; b1.state_in1 = '0; b1.start = 1'b1;
    @(negedge clk);
    b1.start = 1'b0;
    repeat (7) @(negedge clk);
    total++;
    if ({b1.busy, b1.r_req, b1.sbox_in0, b1.sbox_in1} !== {2'b11, 4'h8, 4'h0})
      $display("FAIL mid_issue_idx7: got busy/r_req=%b%b sbox_in=%h/%h expected 11 8/0",
               b1.busy, b1.r_req, b1.sbox_in0, b1.sbox_in1);
    else passed++;
    rst = 1'b1;
    #1;
    total++;
    if ({b1.busy, b1.r_req, b1.done} !== 3'b000)
      $display("FAIL mid_reset_flags: got busy/r_req/done=%b expected 000", {b1.busy, b1.r_req, b1.done});
    else passed++;
    total++;
    if ({b1.state_out0, b1.state_out1} !== 128'h0)
      $display("FAIL mid_reset_state_out: got %h_%h expected 0", b1.state_out0, b1.state_out1);
    else passed++;
    @(negedge clk);
    rst = 1'b0;
    run1(VEC_A, 64'h0, EXP_A, 1'b0, "after_reset");
  endtask

  task automatic test_back_to_back();
    run1(VEC_A, 64'h0, EXP_A, 1'b1, "b2b_first");
    run1(VEC_B ^ 64'h5A5A_A5A5_3C3C_C3C3, 64'h5A5A_A5A5_3C3C_C3C3, EXP_B, 1'b1, "b2b_second");
  endtask

  initial begin
    b1.start = 1'b0; b1.state_in0 = '0; b1.state_in1 = '0;
    b0.start = 1'b0; b0.state_in0 = '0; b0.state_in1 = '0;
    b3.start = 1'b0; b3.state_in0 = '0; b3.state_in1 = '0;
    test_reset();
    test_case1();
    test_random_shares();
    test_latency();
    test_ignored_start();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
